// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Optional forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rfState_t;

    localparam int DEF_W     = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: sweeps every entry once after reset, then holds RUN.
// Drives the array's init write port and the ready flag.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    output logic          initWe,
    output logic [AW-1:0] initIdx
);

    rfState_t      state;
    rfState_t      stateNext;
    logic [AW-1:0] idx;
    logic [AW-1:0] idxNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        initWe    = 1'b0;
        case (state)
            INIT: begin
                initWe  = 1'b1;
                idxNext = idx + AW'(1);
                if (idx == AW'(DEPTH - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    assign ready   = (state == RUN);
    assign initIdx = idx;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with pending scoreboard bits.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int             W         = DEF_W,
    parameter int             DEPTH     = DEF_DEPTH,
    parameter int             AW        = $clog2(DEPTH),
    parameter int             NREAD     = DEF_NREAD,
    parameter bit             ZERO_REG  = 1'b1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD*W-1:0]  rd_data,
    output logic [NREAD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_addr
);

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pendNext;
    logic             initWe;
    logic [AW-1:0]    initIdx;
    logic             wrOk;
    logic             setOk;

    function automatic logic isZero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    regfile_init_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uInitSeq (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready   (ready),
        .initWe  (initWe),
        .initIdx (initIdx)
    );

    assign wrOk  = ready && wr_en && !isZero(wr_addr);
    assign setOk = ready && busy_set && !isZero(busy_addr);

    // Storage has no reset; the init sequencer is what defines its contents.
    always_ff @(posedge clk) begin
        if (initWe) begin
            mem[initIdx] <= RESET_VAL;
        end else if (wrOk) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so a new producer wins over writeback.
    always_comb begin
        pendNext = pending;
        if (wrOk) begin
            pendNext[wr_addr] = 1'b0;
        end
        if (setOk) begin
            pendNext[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pendNext;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : gRead
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          b;

        assign a = rd_addr[k*AW +: AW];

        always_comb begin
            d = mem[a];
            b = pending[a];
`ifdef REGFILE_BYPASS_EN
            if (wrOk && (wr_addr == a)) begin
                d = wr_data;
            end
            b = pendNext[a];
`endif
            if (!ready || isZero(a)) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[k*W +: W] = d;
        assign rd_busy[k]        = b;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed-vector bench for reg_file_mp (DEPTH=32, RESET_VAL=5, two read ports).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_reg_file_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam logic [W-1:0] RV = 32'h5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ready;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            busy_set = 1'b0;
    logic [AW-1:0]   busy_addr = '0;

    int checks = 0;
    int failures = 0;

    reg_file_mp #(
        .W         (W),
        .DEPTH     (D),
        .NREAD     (NR),
        .ZERO_REG  (1'b1),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [W-1:0]  e0;
        logic [W-1:0]  e1;
        logic [1:0]    eb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        busy_set = 1'b0;
    endtask

    task automatic edgeStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts init edges; ready must rise exactly after edge D.
    task automatic runInit(input string tag);
        for (int c = 1; c <= D; c++) begin
            edgeStep();
            if (c == D) idle();
            #1;
            chk($sformatf("%s_ready_e%0d", tag, c), {31'b0, ready},
                (c == D) ? 32'd1 : 32'd0);
            if (c == D - 1) begin
                chk($sformatf("%s_rd0_preready", tag), rd_data[31:0], 32'h0);
            end
        end
    endtask

    task automatic sweep(input string tag);
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
        for (int a = 0; a < D; a++) begin
            setRd(AW'(a), AW'(D - 1 - a));
            #1;
            exp0 = (a == 0) ? 32'h0 : RV;
            exp1 = (a == D - 1) ? 32'h0 : RV;
            chk($sformatf("%s_rd0_a%0d", tag, a), rd_data[31:0], exp0);
            chk($sformatf("%s_rd1_a%0d", tag, D - 1 - a), rd_data[63:32], exp1);
            chk($sformatf("%s_busy_a%0d", tag, a), {30'b0, rd_busy}, 32'h0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  5'd0,  5'd0,
                    32'h0,        32'h0,    2'b00};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd7,
                    RV,           RV,       2'b11};
        vecs[2] = '{1'b1, 5'd7,  32'h1234,     1'b0, 5'd0,  5'd7,  5'd3,
                    32'h1234,     RV,       2'b00};
        vecs[3] = '{1'b1, 5'd9,  32'hCAFE,     1'b1, 5'd9,  5'd9,  5'd9,
                    32'hCAFE,     32'hCAFE, 2'b11};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd31, 5'd30,
                    32'hFFFFFFFF, RV,       2'b00};
        vecs[5] = '{1'b1, 5'd13, 32'h77,       1'b1, 5'd12, 5'd12, 5'd13,
                    RV,           32'h77,   2'b01};
        vecs[6] = '{1'b1, 5'd12, 32'h88,       1'b0, 5'd0,  5'd12, 5'd9,
                    32'h88,       32'hCAFE, 2'b10};

        // Held in reset
        setRd(5'd1, 5'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_busy", {30'b0, rd_busy}, 32'h0);

        // Release; try to write and mark pending during INIT
        rst_n     = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'hAA;
        busy_set  = 1'b1;
        busy_addr = 5'd4;
        setRd(5'd3, 5'd4);
        runInit("init");
        setRd(5'd3, 5'd4);
        #1;
        chk("init_wr_ignored", rd_data[31:0], RV);
        chk("init_busy_ignored", {30'b0, rd_busy}, 32'h0);
        sweep("post_init");

        // Table-driven vectors, checked after the edge with inputs idle
        for (int i = 0; i < 7; i++) begin
            wr_en     = vecs[i].we;
            wr_addr   = vecs[i].wa;
            wr_data   = vecs[i].wd;
            busy_set  = vecs[i].bs;
            busy_addr = vecs[i].ba;
            setRd(vecs[i].r0, vecs[i].r1);
            edgeStep();
            idle();
            #1;
            chk($sformatf("vec%0d_rd0", i), rd_data[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].e1);
            chk($sformatf("vec%0d_busy", i), {30'b0, rd_busy}, {30'b0, vecs[i].eb});
        end

        // Same-cycle view of a writeback to a pending register
        busy_set  = 1'b1;
        busy_addr = 5'd20;
        setRd(5'd20, 5'd20);
        edgeStep();
        idle();
        #1;
        chk("byp_pending", {31'b0, rd_busy[0]}, 32'h1);
        wr_en   = 1'b1;
        wr_addr = 5'd20;
        wr_data = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_data", rd_data[31:0], 32'h1234);
        chk("byp_same_busy", {31'b0, rd_busy[0]}, 32'h0);
`else
        chk("byp_same_data", rd_data[31:0], RV);
        chk("byp_same_busy", {31'b0, rd_busy[0]}, 32'h1);
`endif
        edgeStep();
        idle();
        #1;
        chk("byp_after_data", rd_data[31:0], 32'h1234);
        chk("byp_after_busy", {31'b0, rd_busy[0]}, 32'h0);

        // Write plus set on one address: forwarded busy reflects the set
        wr_en     = 1'b1;
        wr_addr   = 5'd21;
        wr_data   = 32'h55;
        busy_set  = 1'b1;
        busy_addr = 5'd21;
        setRd(5'd21, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_ws_data", rd_data[31:0], 32'h55);
        chk("byp_ws_busy", {31'b0, rd_busy[0]}, 32'h1);
`else
        chk("byp_ws_data", rd_data[31:0], RV);
        chk("byp_ws_busy", {31'b0, rd_busy[0]}, 32'h0);
`endif
        edgeStep();
        idle();
        #1;
        chk("ws_after_data", rd_data[31:0], 32'h55);
        chk("ws_after_busy", {31'b0, rd_busy[0]}, 32'h1);

        // Reset mid-run: outputs drop immediately, then a full re-init
        setRd(5'd9, 5'd12);
        #1;
        chk("pre_rst_data", rd_data[31:0], 32'hCAFE);
        chk("pre_rst_busy", {31'b0, rd_busy[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, ready}, 32'h0);
        chk("mid_rst_rd0", rd_data[31:0], 32'h0);
        chk("mid_rst_rd1", rd_data[63:32], 32'h0);
        chk("mid_rst_busy", {30'b0, rd_busy}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runInit("reinit");
        sweep("post_reinit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
